// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-port memory arbiter.
//   state_e        : arbiter FSM states (IDLE -> ISSUE -> RESP -> IDLE)
//   CONSOLE_ADDR_DEFAULT : default byte address of the console write register
//   aw_from_bytes  : RAM word-address width for a RAM of the given byte size
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic [31:0] CONSOLE_ADDR_DEFAULT = 32'h1000_0000;

  // Word-address width: log2(mem_bytes / 4); mem_bytes is a power of two >= 8.
  function automatic int unsigned aw_from_bytes(input int unsigned mem_bytes);
    return $clog2(mem_bytes / 32'd4);
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// -----------------------------------------------------------------------------
// mem_arb_rr
// Two-request picker with a last-grant register.
//   clk_i        : clock
//   resetn_i     : synchronous active-low reset (last grant -> 1, so port 0
//                  wins the first contended pick)
//   req_i[1:0]   : per-port request
//   update_i     : load the current pick into the last-grant register
//   grant_o      : combinational pick (0 = port 0, 1 = port 1)
//   last_grant_o : registered last grant; equals the active grant while a
//                  transaction is in flight
// RR_EN = 1 alternates on contention; RR_EN = 0 lets port 0 always win.
// -----------------------------------------------------------------------------
module mem_arb_rr #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       grant_o,
  output logic       last_grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  // Grant selection and last-grant next state
  always_comb begin
    grant_o      = 1'b0;
    last_grant_d = last_grant_q;
    if (RR_EN && (req_i == 2'b11)) begin
      grant_o = ~last_grant_q;
    end else if (req_i[0]) begin
      grant_o = 1'b0;
    end else if (req_i[1]) begin
      grant_o = 1'b1;
    end else begin
      grant_o = 1'b0;
    end
    if (update_i) begin
      last_grant_d = grant_o;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Last-grant register
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant_o = last_grant_q;

endmodule

// File: rtl/mem_arbiter2.sv
// -----------------------------------------------------------------------------
// mem_arbiter2
// Shares one single-port synchronous RAM between two picorv32-style native
// memory requesters (port 0 = CPU, port 1 = DMA/loader) and decodes a console
// MMIO write register to a byte stream.
//
// Ports:
//   clk, resetn                 : clock, synchronous active-low reset
//   mN_valid/addr/wdata/wstrb   : requester N request (wstrb == 0 -> read)
//   mN_ready/rdata              : one-cycle completion pulse and read data
//   ram_en/addr/wdata/wstrb     : RAM access (word address, byte enables)
//   ram_rdata                   : RAM read data, one cycle after ram_en
//   con_valid/con_data          : console byte strobe and byte
//   bus_err                     : sticky out-of-range flag (MEM_ARB_ERR_EN only)
//
// Configuration macro: MEM_ARB_ERR_EN
//   defined   : addresses >= MEM_BYTES (other than the console) are rejected,
//               read as zero, and set the sticky bus_err output.
//   undefined : no bus_err port; addresses alias modulo MEM_BYTES.
//
// Every transaction is IDLE -> ISSUE -> RESP -> IDLE; all outputs are
// registered, so ready is visible in the cycle after the RESP state.
// -----------------------------------------------------------------------------
module mem_arbiter2
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES     = 262144,
  parameter logic [31:0] CONSOLE_ADDR  = CONSOLE_ADDR_DEFAULT,
  parameter int unsigned RR_EN_DEFAULT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        ram_en,
  output logic [aw_from_bytes(MEM_BYTES)-1:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wstrb,
  input  logic [31:0] ram_rdata,
`ifdef MEM_ARB_ERR_EN
  output logic        bus_err,
`endif
  output logic        con_valid,
  output logic [7:0]  con_data
);

  localparam int unsigned AW = aw_from_bytes(MEM_BYTES);

  state_e         state_q, state_d;
  logic           m0_ready_q, m0_ready_d;
  logic           m1_ready_q, m1_ready_d;
  logic [31:0]    m0_rdata_q, m0_rdata_d;
  logic [31:0]    m1_rdata_q, m1_rdata_d;
  logic           ram_en_q, ram_en_d;
  logic [AW-1:0]  ram_addr_q, ram_addr_d;
  logic [31:0]    ram_wdata_q, ram_wdata_d;
  logic [3:0]     ram_wstrb_q, ram_wstrb_d;
  logic           con_valid_q, con_valid_d;
  logic [7:0]     con_data_q, con_data_d;
  // Set when the in-flight access is a RAM read, so RESP returns RAM data.
  logic           rd_ram_q, rd_ram_d;
`ifdef MEM_ARB_ERR_EN
  logic           bus_err_q, bus_err_d;
`endif

  logic [1:0]     req;
  logic           pick;
  logic           cur_grant;
  logic           take;
  logic [31:0]    sel_addr;
  logic [31:0]    sel_wdata;
  logic [3:0]     sel_wstrb;
  logic           sel_is_con;
  logic           sel_is_wr;
  logic           sel_oor;

  // A port whose ready is high this cycle still shows valid (the requester
  // drops it on the closing edge), so it is masked to avoid a phantom repeat.
  assign req  = {m1_valid & ~m1_ready_q, m0_valid & ~m0_ready_q};
  assign take = (state_q == IDLE) && (req != 2'b00);

  mem_arb_rr #(
    .RR_EN (RR_EN_DEFAULT != 0)
  ) u_rr (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .req_i        (req),
    .update_i     (take),
    .grant_o      (pick),
    .last_grant_o (cur_grant)
  );

  assign sel_addr   = pick ? m1_addr  : m0_addr;
  assign sel_wdata  = pick ? m1_wdata : m0_wdata;
  assign sel_wstrb  = pick ? m1_wstrb : m0_wstrb;
  assign sel_is_con = (sel_addr == CONSOLE_ADDR);
  assign sel_is_wr  = (sel_wstrb != 4'b0000);

`ifdef MEM_ARB_ERR_EN
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
  assign sel_oor = ({1'b0, sel_addr} >= MEM_LIMIT);
`else
  assign sel_oor = 1'b0;
`endif

  // FSM next state and registered-output next values
  always_comb begin
    state_d     = state_q;
    m0_ready_d  = 1'b0;
    m1_ready_d  = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    ram_en_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_wstrb_d = ram_wstrb_q;
    con_valid_d = 1'b0;
    con_data_d  = con_data_q;
    rd_ram_d    = rd_ram_q;
`ifdef MEM_ARB_ERR_EN
    bus_err_d   = bus_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d     = ISSUE;
          ram_addr_d  = sel_addr[AW+1:2];
          ram_wdata_d = sel_wdata;
          ram_wstrb_d = sel_wstrb;
          rd_ram_d    = 1'b0;
          if (sel_is_con) begin
            // Console: writes emit a byte, reads return zero; never hits RAM.
            if (sel_is_wr) begin
              con_valid_d = 1'b1;
              con_data_d  = sel_wdata[7:0];
            end else begin
              con_valid_d = 1'b0;
            end
          end else if (sel_oor) begin
            // Rejected access: no RAM cycle, response is zero.
`ifdef MEM_ARB_ERR_EN
            bus_err_d = 1'b1;
`endif
          end else begin
            ram_en_d = 1'b1;
            rd_ram_d = ~sel_is_wr;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = RESP;
      end
      RESP: begin
        // RAM data for the ISSUE-cycle read is on ram_rdata now.
        state_d = IDLE;
        if (cur_grant) begin
          m1_ready_d = 1'b1;
          m1_rdata_d = rd_ram_q ? ram_rdata : 32'h0000_0000;
        end else begin
          m0_ready_d = 1'b1;
          m0_rdata_d = rd_ram_q ? ram_rdata : 32'h0000_0000;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      m0_ready_q  <= 1'b0;
      m1_ready_q  <= 1'b0;
      m0_rdata_q  <= 32'h0000_0000;
      m1_rdata_q  <= 32'h0000_0000;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'h0000_0000;
      ram_wstrb_q <= 4'b0000;
      con_valid_q <= 1'b0;
      con_data_q  <= 8'h00;
      rd_ram_q    <= 1'b0;
`ifdef MEM_ARB_ERR_EN
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      m0_ready_q  <= m0_ready_d;
      m1_ready_q  <= m1_ready_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      ram_en_q    <= ram_en_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wstrb_q <= ram_wstrb_d;
      con_valid_q <= con_valid_d;
      con_data_q  <= con_data_d;
      rd_ram_q    <= rd_ram_d;
`ifdef MEM_ARB_ERR_EN
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign m0_ready  = m0_ready_q;
  assign m1_ready  = m1_ready_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign ram_en    = ram_en_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_wstrb = ram_wstrb_q;
  assign con_valid = con_valid_q;
  assign con_data  = con_data_q;
`ifdef MEM_ARB_ERR_EN
  assign bus_err   = bus_err_q;
`endif

endmodule

// File: tb/tb_mem_arbiter2.sv
`timescale 1ns/1ps
module tb_mem_arbiter2;

  localparam int AW = 16;
  localparam logic [31:0] CON = 32'h1000_0000;

  logic          clk = 1'b0;
  logic          resetn;
  logic          m0_valid, m1_valid;
  logic [31:0]   m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]    m0_wstrb, m1_wstrb;
  logic          m0_ready, m1_ready;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [3:0]    ram_wstrb;
  logic [31:0]   ram_rdata = 32'h0;
  logic          con_valid;
  logic [7:0]    con_data;
`ifdef MEM_ARB_ERR_EN
  logic          bus_err;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_arbiter2 dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb),
    .ram_rdata(ram_rdata),
`ifdef MEM_ARB_ERR_EN
    .bus_err(bus_err),
`endif
    .con_valid(con_valid), .con_data(con_data)
  );

  // Synchronous single-port RAM model with byte enables, one-cycle read.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_wstrb[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  // Event monitor: values seen during the cycle that ends at each posedge.
  int cyc = 0, ram_en_cnt = 0, con_cnt = 0, rdy0_cnt = 0, rdy1_cnt = 0, both_cnt = 0;
  logic [7:0]    last_con = 8'h0;
  logic [AW-1:0] last_ram_addr = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en) begin ram_en_cnt <= ram_en_cnt + 1; last_ram_addr <= ram_addr; end
    if (con_valid) begin con_cnt <= con_cnt + 1; last_con <= con_data; end
    if (m0_ready) rdy0_cnt <= rdy0_cnt + 1;
    if (m1_ready) rdy1_cnt <= rdy1_cnt + 1;
    if (m0_ready && m1_ready) both_cnt <= both_cnt + 1;
  end

  // One transaction on one port; called and returning on a negedge, with one
  // idle cycle after ready so the next call sees the uncontended latency.
  task automatic txn(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, output logic [31:0] rdata, output int lat);
    lat = 0;
    rdata = 32'hxxxx_xxxx;
    if (port == 0) begin m0_valid = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb; end
    else           begin m1_valid = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb; end
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (port == 0 && m0_ready) begin rdata = m0_rdata; break; end
      if (port == 1 && m1_ready) begin rdata = m1_rdata; break; end
    end
    m0_valid = 1'b0; m1_valid = 1'b0; m0_wstrb = 4'h0; m1_wstrb = 4'h0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({m0_ready, m1_ready, ram_en, con_valid} !== 4'b0000)
      $display("FAIL reset_strobes: got %b want 0000", {m0_ready, m1_ready, ram_en, con_valid});
    else n_pass++;
    n_total++;
    if ({m0_rdata, m1_rdata} !== 64'h0)
      $display("FAIL reset_rdata: got %h %h want 0 0", m0_rdata, m1_rdata);
    else n_pass++;
    n_total++;
    if ({ram_addr, ram_wdata, ram_wstrb, con_data} !== 60'h0)
      $display("FAIL reset_ram_con: got %h %h %h %h want 0", ram_addr, ram_wdata, ram_wstrb, con_data);
    else n_pass++;
`ifdef MEM_ARB_ERR_EN
    n_total++;
    if (bus_err !== 1'b0) $display("FAIL reset_bus_err: got %b want 0", bus_err);
    else n_pass++;
`endif
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    logic [31:0] rd; int lat; int e0;
    e0 = ram_en_cnt;
    txn(0, 32'h100, 32'hDEAD_BEEF, 4'hF, rd, lat);
    n_total++;
    if (lat !== 3) $display("FAIL wr_latency: got %0d want 3", lat); else n_pass++;
    n_total++;
    if (last_ram_addr !== 16'h0040) $display("FAIL wr_ram_addr: got %h want 0040", last_ram_addr); else n_pass++;
    txn(0, 32'h100, 32'h0, 4'h0, rd, lat);
    n_total++;
    if (lat !== 3) $display("FAIL rd_latency: got %0d want 3", lat); else n_pass++;
    n_total++;
    if (rd !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h want deadbeef", rd); else n_pass++;
    n_total++;
    if (ram_en_cnt - e0 !== 2) $display("FAIL wr_rd_ram_en: got %0d want 2", ram_en_cnt - e0); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; int lat;
    int t0[10]; int t1[10]; logic [31:0] d0[10]; logic [31:0] d1[10];
    int n0, n1, r0, r1, b0;
    // Preload through the arbiter; port 1 goes last so round-robin favours port 0.
    for (int i = 0; i < 10; i++) txn(0, 32'h1000 + 4*i, 32'hA000_0000 + i, 4'hF, rd, lat);
    for (int i = 0; i < 10; i++) txn(1, 32'h2000 + 4*i, 32'hB000_0000 + i, 4'hF, rd, lat);
    r0 = rdy0_cnt; r1 = rdy1_cnt; b0 = both_cnt;
    n0 = 0; n1 = 0;
    m0_addr = 32'h1000; m0_wstrb = 4'h0; m0_valid = 1'b1;
    m1_addr = 32'h2000; m1_wstrb = 4'h0; m1_valid = 1'b1;
    fork
      begin
        for (int k = 0; k < 300 && n0 < 10; k++) begin
          @(negedge clk);
          if (m0_ready) begin
            d0[n0] = m0_rdata; t0[n0] = cyc; n0++;
            if (n0 < 10) m0_addr = 32'h1000 + 4*n0; else m0_valid = 1'b0;
          end
        end
        m0_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 300 && n1 < 10; k++) begin
          @(negedge clk);
          if (m1_ready) begin
            d1[n1] = m1_rdata; t1[n1] = cyc; n1++;
            if (n1 < 10) m1_addr = 32'h2000 + 4*n1; else m1_valid = 1'b0;
          end
        end
        m1_valid = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    n_total++;
    if (n0 !== 10 || n1 !== 10) $display("FAIL b2b_count: got %0d/%0d want 10/10", n0, n1);
    else n_pass++;
    if (n0 == 10 && n1 == 10) begin
      n_total++;
      if (t1[0] - t0[0] !== 3) $display("FAIL b2b_first_order: got p1-p0=%0d want 3", t1[0] - t0[0]);
      else n_pass++;
      for (int i = 1; i < 10; i++) begin
        n_total++;
        if (t0[i] - t0[i-1] !== 6 || t1[i] - t1[i-1] !== 6)
          $display("FAIL b2b_period[%0d]: got %0d/%0d want 6/6", i, t0[i] - t0[i-1], t1[i] - t1[i-1]);
        else n_pass++;
      end
      for (int i = 0; i < 10; i++) begin
        n_total++;
        if (d0[i] !== 32'hA000_0000 + i || d1[i] !== 32'hB000_0000 + i)
          $display("FAIL b2b_data[%0d]: got %h/%h want %h/%h", i, d0[i], d1[i],
                   32'hA000_0000 + i, 32'hB000_0000 + i);
        else n_pass++;
      end
    end
    n_total++;
    if (rdy0_cnt - r0 !== 10 || rdy1_cnt - r1 !== 10 || both_cnt !== b0)
      $display("FAIL b2b_ready_pulses: got %0d/%0d both=%0d want 10/10 both=0",
               rdy0_cnt - r0, rdy1_cnt - r1, both_cnt - b0);
    else n_pass++;
  endtask

  task automatic test_console;
    logic [31:0] rd; int lat; int e0, c0;
    e0 = ram_en_cnt; c0 = con_cnt;
    txn(1, CON, 32'h0000_0041, 4'hF, rd, lat);
    n_total++;
    if (lat !== 3) $display("FAIL con_latency: got %0d want 3", lat); else n_pass++;
    n_total++;
    if (con_cnt - c0 !== 1 || last_con !== 8'h41)
      $display("FAIL con_pulse: got %0d pulses data %h want 1 pulse data 41", con_cnt - c0, last_con);
    else n_pass++;
    n_total++;
    if (ram_en_cnt !== e0) $display("FAIL con_ram_en: got %0d want 0", ram_en_cnt - e0); else n_pass++;
    // Console read returns zero (m1_rdata currently holds a prior value).
    txn(1, 32'h2000, 32'h0, 4'h0, rd, lat);
    txn(1, CON, 32'h0, 4'h0, rd, lat);
    n_total++;
    if (rd !== 32'h0 || con_cnt - c0 !== 1)
      $display("FAIL con_read: got %h pulses %0d want 0 pulses 1", rd, con_cnt - c0);
    else n_pass++;
  endtask

  task automatic test_byte_write;
    logic [31:0] rd; int lat;
    txn(0, 32'h200, 32'h1122_3344, 4'hF, rd, lat);
    txn(0, 32'h200, 32'h00AB_0000, 4'b0100, rd, lat);
    txn(0, 32'h200, 32'h0, 4'h0, rd, lat);
    n_total++;
    if (rd !== 32'h11AB_3344) $display("FAIL byte_write: got %h want 11ab3344", rd); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int r0; int w;
    // Port 0 write makes last_grant 0; only reset can return priority to port 0.
    m0_addr = 32'h300; m0_wdata = 32'hCAFE_0300; m0_wstrb = 4'hF; m0_valid = 1'b1;
    @(negedge clk);
    n_total++;
    if (ram_en !== 1'b1) $display("FAIL rst_issue_en: got %b want 1", ram_en); else n_pass++;
    resetn = 1'b0;
    @(negedge clk);
    n_total++;
    if ({m0_ready, m1_ready, ram_en, con_valid, ram_wstrb, ram_addr, ram_wdata} !== 56'h0)
      $display("FAIL rst_mid_outputs: got %b%b%b%b %h %h %h want 0", m0_ready, m1_ready, ram_en,
               con_valid, ram_wstrb, ram_addr, ram_wdata);
    else n_pass++;
    resetn = 1'b1; m0_valid = 1'b0; m0_wstrb = 4'h0;
    r0 = rdy0_cnt + rdy1_cnt;
    repeat (6) @(negedge clk);
    n_total++;
    if (rdy0_cnt + rdy1_cnt !== r0) $display("FAIL rst_no_ready: got %0d readies want 0", rdy0_cnt + rdy1_cnt - r0);
    else n_pass++;
    m0_addr = 32'h300; m0_valid = 1'b1;
    m1_addr = 32'h200; m1_wstrb = 4'h0; m1_valid = 1'b1;
    w = 0;
    while (w < 12 && !m0_ready && !m1_ready) begin @(negedge clk); w++; end
    n_total++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || m0_rdata !== 32'hCAFE_0300)
      $display("FAIL rst_next_grant: got r0=%b r1=%b d=%h want r0=1 r1=0 d=cafe0300", m0_ready, m1_ready, m0_rdata);
    else n_pass++;
    m0_valid = 1'b0;
    w = 0;
    while (w < 12 && !m1_ready) begin @(negedge clk); w++; end
    n_total++;
    if (m1_ready !== 1'b1 || m1_rdata !== 32'h11AB_3344)
      $display("FAIL rst_second_grant: got r1=%b d=%h want r1=1 d=11ab3344", m1_ready, m1_rdata);
    else n_pass++;
    m1_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd; int lat; int e0;
    txn(0, 32'h0, 32'h0BAD_F00D, 4'hF, rd, lat);
    e0 = ram_en_cnt;
    txn(0, 32'h0004_0000, 32'h0, 4'h0, rd, lat);
    n_total++;
    if (lat !== 3) $display("FAIL oor_latency: got %0d want 3", lat); else n_pass++;
`ifdef MEM_ARB_ERR_EN
    n_total++;
    if (rd !== 32'h0 || ram_en_cnt !== e0 || bus_err !== 1'b1)
      $display("FAIL oor_err: got d=%h en=%0d err=%b want d=0 en=0 err=1", rd, ram_en_cnt - e0, bus_err);
    else n_pass++;
    txn(0, 32'h0, 32'h0, 4'h0, rd, lat);
    n_total++;
    if (rd !== 32'h0BAD_F00D || bus_err !== 1'b1)
      $display("FAIL oor_sticky: got d=%h err=%b want d=0badf00d err=1", rd, bus_err);
    else n_pass++;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    n_total++;
    if (bus_err !== 1'b0) $display("FAIL oor_err_clear: got %b want 0", bus_err); else n_pass++;
`else
    n_total++;
    if (rd !== 32'h0BAD_F00D || last_ram_addr !== 16'h0000 || ram_en_cnt - e0 !== 1)
      $display("FAIL oor_alias: got d=%h a=%h en=%0d want d=0badf00d a=0000 en=1", rd, last_ram_addr, ram_en_cnt - e0);
    else n_pass++;
`endif
  endtask

  initial begin
    resetn = 1'b0;
    m0_valid = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_console();
    test_byte_write();
    test_reset_mid();
    test_out_of_range();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
